// File: rtl/hazard_stall_unit_if.sv
// Pipeline-control bundle between the decode/execute/memory datapath and hazard_stall_unit.
// The slave side is the hazard unit; the master side is the datapath that supplies addresses and consumes enables.
interface hazard_stall_unit_if #(
  parameter int ADDR_W = 3
);
  logic [ADDR_W-1:0] D_src_add_1;
  logic [ADDR_W-1:0] D_src_add_2;
  logic              D_src_use_1;
  logic              D_src_use_2;
  logic [ADDR_W-1:0] E_dst_add;
  logic              E_WB;
  logic              E_mem_read;
  logic              M_mem_busy;
  logic              flush;
  logic              pc_en;
  logic              fd_en;
  logic              fd_flush;
  logic              de_en;
  logic              de_bubble;
  logic              em_en;
  logic [15:0]       stall_cnt;

  modport master (
    output D_src_add_1, D_src_add_2, D_src_use_1, D_src_use_2,
           E_dst_add, E_WB, E_mem_read, M_mem_busy, flush,
    input  pc_en, fd_en, fd_flush, de_en, de_bubble, em_en, stall_cnt
  );

  modport slave (
    input  D_src_add_1, D_src_add_2, D_src_use_1, D_src_use_2,
           E_dst_add, E_WB, E_mem_read, M_mem_busy, flush,
    output pc_en, fd_en, fd_flush, de_en, de_bubble, em_en, stall_cnt
  );
endinterface

// File: rtl/hazard_stall_unit.sv
// Load-use stall, memory freeze and flush sequencing for the PC, F/D, D/E and E/M registers.
// Optional stall performance counter compiled in with `define HAZARD_PERF_CNT_EN.
module hazard_stall_unit #(
  parameter int ADDR_W   = 3,
  parameter int LOAD_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  hazard_stall_unit_if.slave bus
);

  typedef enum logic {RUN = 1'b0, LOAD_STALL = 1'b1} state_t;

  localparam logic [2:0] LCNT_INIT = 3'(LOAD_LAT - 1);

  state_t            state_q, state_n;
  logic [2:0]        lcnt_q, lcnt_n;
  logic              pend_q, pend_n;
  logic [ADDR_W-1:0] src1, src2, dst;
  logic              hazard;
  logic              pc_en, fd_en, fd_flush, de_en, de_bubble, em_en;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign src1   = bus.D_src_add_1;
  assign src2   = bus.D_src_add_2;
  assign dst    = bus.E_dst_add;
  assign hazard = bus.E_mem_read & bus.E_WB &
                  ((bus.D_src_use_1 & (src1 == dst)) |
                   (bus.D_src_use_2 & (src2 == dst)));

  always_comb begin
    state_n   = state_q;
    lcnt_n    = lcnt_q;
    pend_n    = pend_q;
    pc_en     = 1'b1;
    fd_en     = 1'b1;
    fd_flush  = 1'b0;
    de_en     = 1'b1;
    de_bubble = 1'b0;
    em_en     = 1'b1;
    if (rst) begin
      pc_en     = 1'b0;
      fd_en     = 1'b0;
      de_en     = 1'b0;
      em_en     = 1'b0;
      fd_flush  = 1'b1;
      de_bubble = 1'b1;
    end else if (bus.M_mem_busy) begin
      // Freeze holds the stall countdown; a flush seen now is remembered.
      pc_en  = 1'b0;
      fd_en  = 1'b0;
      de_en  = 1'b0;
      em_en  = 1'b0;
      pend_n = pend_q | bus.flush;
    end else if (bus.flush | pend_q) begin
      fd_flush  = 1'b1;
      de_bubble = 1'b1;
      state_n   = RUN;
      lcnt_n    = 3'd0;
      pend_n    = 1'b0;
    end else if ((state_q == RUN && hazard) || state_q == LOAD_STALL) begin
      pc_en     = 1'b0;
      fd_en     = 1'b0;
      de_bubble = 1'b1;
      if (state_q == RUN) begin
        if (LOAD_LAT > 1) begin
          state_n = LOAD_STALL;
          lcnt_n  = LCNT_INIT;
        end
      end else begin
        lcnt_n = lcnt_q - 3'd1;
        if (lcnt_q == 3'd1) state_n = RUN;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      lcnt_q  <= 3'd0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      lcnt_q  <= lcnt_n;
      pend_q  <= pend_n;
    end
  end

  assign bus.pc_en     = pc_en;
  assign bus.fd_en     = fd_en;
  assign bus.fd_flush  = fd_flush;
  assign bus.de_en     = de_en;
  assign bus.de_bubble = de_bubble;
  assign bus.em_en     = em_en;

`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cnt_q <= 16'h0000;
    else if (!pc_en) stall_cnt_q <= sat_inc(stall_cnt_q);
  end

  assign bus.stall_cnt = stall_cnt_q;
`else
  assign bus.stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Randomized and directed check of hazard_stall_unit at LOAD_LAT=1 and LOAD_LAT=3 against a stall-budget model.
module tb_hazard_stall_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] s1 = '0, s2 = '0, ed = '0;
  logic       u1 = 1'b0, u2 = 1'b0, wb = 1'b0, mr = 1'b0, busy = 1'b0, fl = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  int m_rem  [2];
  bit m_pend [2];
  int m_cnt  [2];
  int lat    [2] = '{1, 3};

  hazard_stall_unit_if #(.ADDR_W(3)) ifa ();
  hazard_stall_unit_if #(.ADDR_W(3)) ifb ();

  assign ifa.D_src_add_1 = s1;  assign ifb.D_src_add_1 = s1;
  assign ifa.D_src_add_2 = s2;  assign ifb.D_src_add_2 = s2;
  assign ifa.D_src_use_1 = u1;  assign ifb.D_src_use_1 = u1;
  assign ifa.D_src_use_2 = u2;  assign ifb.D_src_use_2 = u2;
  assign ifa.E_dst_add   = ed;  assign ifb.E_dst_add   = ed;
  assign ifa.E_WB        = wb;  assign ifb.E_WB        = wb;
  assign ifa.E_mem_read  = mr;  assign ifb.E_mem_read  = mr;
  assign ifa.M_mem_busy  = busy; assign ifb.M_mem_busy = busy;
  assign ifa.flush       = fl;  assign ifb.flush       = fl;

  hazard_stall_unit #(.ADDR_W(3), .LOAD_LAT(1)) u_lat1 (.clk(clk), .rst(rst), .bus(ifa));
  hazard_stall_unit #(.ADDR_W(3), .LOAD_LAT(3)) u_lat3 (.clk(clk), .rst(rst), .bus(ifb));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // {pc_en, fd_en, fd_flush, de_en, de_bubble, em_en}
  function automatic logic [5:0] model_out(input int k, input bit hz);
    if (rst)                        return 6'b00_1_0_1_0;
    if (busy)                       return 6'b00_0_0_0_0;
    if (fl || m_pend[k])            return 6'b11_1_1_1_1;
    if (m_rem[k] > 0 || hz)         return 6'b00_0_1_1_1;
    return 6'b11_0_1_0_1;
  endfunction

  task automatic step(input logic r, input logic [2:0] a1, input logic [2:0] a2,
                      input logic c1, input logic c2, input logic [2:0] d,
                      input logic w, input logic m, input logic b, input logic f);
    bit         hz;
    logic [5:0] exp_o [2];
    logic [5:0] obs_o [2];
    logic [15:0] obs_c [2];
    @(posedge clk);
    #2;
    rst = r; s1 = a1; s2 = a2; u1 = c1; u2 = c2; ed = d; wb = w; mr = m; busy = b; fl = f;
    #3;
    hz = m && w && ((c1 && a1 == d) || (c2 && a2 == d));
    obs_o[0] = {ifa.pc_en, ifa.fd_en, ifa.fd_flush, ifa.de_en, ifa.de_bubble, ifa.em_en};
    obs_o[1] = {ifb.pc_en, ifb.fd_en, ifb.fd_flush, ifb.de_en, ifb.de_bubble, ifb.em_en};
    obs_c[0] = ifa.stall_cnt;
    obs_c[1] = ifb.stall_cnt;
    for (int k = 0; k < 2; k++) begin
      int exp_c;
      exp_o[k] = model_out(k, hz);
`ifdef HAZARD_PERF_CNT_EN
      exp_c = r ? 0 : m_cnt[k];
`else
      exp_c = 0;
`endif
      chk(k == 0 ? "lat1_ctl" : "lat3_ctl", 32'(obs_o[k]), 32'(exp_o[k]));
      chk(k == 0 ? "lat1_cnt" : "lat3_cnt", 32'(obs_c[k]), 32'(exp_c));
      // Advance the model to the state after the next rising edge.
      if (r) begin
        m_rem[k] = 0; m_pend[k] = 0; m_cnt[k] = 0;
      end else begin
        if (!exp_o[k][5]) m_cnt[k] = (m_cnt[k] >= 65535) ? 65535 : m_cnt[k] + 1;
        if (b)                     m_pend[k] = m_pend[k] | f;
        else if (f || m_pend[k]) begin m_rem[k] = 0; m_pend[k] = 0; end
        else if (m_rem[k] > 0)     m_rem[k]--;
        else if (hz)               m_rem[k] = lat[k] - 1;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic hz_pulse(input logic c1, input logic c2);
    step(0, 3'd3, 3'd3, c1, c2, 3'd3, 1, 1, 0, 0);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin m_rem[k] = 0; m_pend[k] = 0; m_cnt[k] = 0; end
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);

    // Single load-use pulse, then the same registers with neither source used.
    hz_pulse(1, 0);
    idle(4);
    hz_pulse(0, 1);
    idle(4);
    hz_pulse(0, 0);
    idle(2);

    // Four busy cycles with a flush in the second; flush lands once afterwards.
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(3);

    // Flush on the second stall cycle squashes the remainder.
    hz_pulse(1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(3);

    // Busy over a stall, and busy alongside a live hazard.
    hz_pulse(1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(3);
    step(0, 3'd5, 0, 1, 0, 3'd5, 1, 1, 1, 0);
    step(0, 3'd5, 0, 1, 0, 3'd5, 1, 1, 0, 0);
    idle(4);

    // Flush together with a hazard, and register 0 as an ordinary address.
    step(0, 3'd2, 0, 1, 0, 3'd2, 1, 1, 0, 1);
    idle(2);
    step(0, 3'd0, 3'd0, 0, 1, 3'd0, 1, 1, 0, 0);
    idle(4);

    // Reset in the middle of a long stall.
    hz_pulse(1, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(3);

    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(0, 63) == 0),
           3'($urandom), 3'($urandom),
           1'($urandom), 1'($urandom),
           3'($urandom),
           ($urandom_range(0, 3) != 0),
           1'($urandom),
           ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 9) == 0));
    end

    // Long freeze drives the performance counter into saturation.
    idle(3);
    for (int i = 0; i < 70000; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_stall_unit.md
# hazard_stall_unit

- Pipeline-control block that produces the stage enables, flushes and bubbles consumed by the decode/execute datapath.
- Covers the three hazards operand forwarding cannot resolve:
  - load-use dependencies (multi-cycle, configurable load latency);
  - multi-cycle memory-stage accesses (full freeze);
  - control flushes from branches and interrupts, including flushes that arrive during a freeze.
- Sits beside the forwarding unit, is fed by the same decode/execute/memory register-address buses, and drives the PC and the F/D, D/E and E/M pipeline registers.

## Interface
Parameters:
- ADDR_W, 3, register-address width
- LOAD_LAT, 1, stall cycles per load-use hazard; legal 1..7

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous, active-high reset
- D_src_add_1  in  ADDR_W  decode-stage source register 1
- D_src_add_2  in  ADDR_W  decode-stage source register 2
- D_src_use_1  in  1  decode instruction reads source 1
- D_src_use_2  in  1  decode instruction reads source 2
- E_dst_add  in  ADDR_W  execute-stage destination register
- E_WB  in  1  execute-stage instruction writes back
- E_mem_read  in  1  execute-stage instruction is a load
- M_mem_busy  in  1  memory stage has not completed its access this cycle
- flush  in  1  branch taken or interrupt; squash F/D and D/E
- pc_en  out  1  PC register load enable
- fd_en  out  1  F/D register load enable
- fd_flush  out  1  F/D register loads a NOP
- de_en  out  1  D/E register load enable
- de_bubble  out  1  D/E register loads a NOP (control signals zeroed)
- em_en  out  1  E/M register load enable
- stall_cnt  out  16  saturating count of cycles with pc_en=0

## Operation
- State: FSM {RUN, LOAD_STALL}; 3-bit countdown `lcnt`; 1-bit `pend_flush`.
- hazard = E_mem_read & E_WB & ((D_src_use_1 & D_src_add_1==E_dst_add) | (D_src_use_2 & D_src_add_2==E_dst_add)).
- Output priority, highest first:
  1. **rst=1**: pc_en=fd_en=de_en=em_en=0, fd_flush=de_bubble=1.
  2. **M_mem_busy=1 (freeze)**: all four enables 0, fd_flush=de_bubble=0. State and `lcnt` hold. If flush=1, set `pend_flush`.
  3. **flush | pend_flush (squash)**:
     - Outputs: all enables 1, fd_flush=1, de_bubble=1.
     - Next state: RUN, `lcnt`=0, `pend_flush`=0.
     - A flush overrides any load-use stall, since the dependent instruction is squashed.
  4. **Load stall**: applies when (RUN & hazard) or in LOAD_STALL.
     - Outputs: pc_en=fd_en=0, de_en=1, de_bubble=1, em_en=1, fd_flush=0.
     - RUN & hazard with LOAD_LAT>1: go to LOAD_STALL, `lcnt`=LOAD_LAT-1.
     - RUN & hazard with LOAD_LAT=1: stay in RUN.
     - In LOAD_STALL: `lcnt` decrements; when `lcnt`==1, return to RUN.
     - Hazard is not re-evaluated while in LOAD_STALL.
  5. **Otherwise**: all enables 1, fd_flush=de_bubble=0.
- Total load-use stall length is exactly LOAD_LAT unfrozen cycles; freeze cycles extend it without consuming `lcnt`.
- Address compare is exact over ADDR_W bits. Register 0 is not special-cased.

## Timing
- Outputs are combinational from current state plus inputs, with no added latency.
- State, `lcnt`, `pend_flush` and `stall_cnt` update on the rising clk edge.
- Reset values: state RUN, `lcnt`=0, `pend_flush`=0, stall_cnt=0.
- Reset asserted mid-stall: the stall aborts immediately. The first cycle after deassert is in RUN with no pending flush.
- Simultaneous events:
  - busy + flush: the flush is deferred to the first non-busy cycle, and is applied exactly once.
  - busy + hazard: freeze only. The stall starts when busy drops and the hazard is still present.
  - flush + hazard: squash only, no stall.
- `stall_cnt` increments on each clocked edge where pc_en=0 and rst=0. It saturates at 16'hFFFF.

## Configuration
- `HAZARD_PERF_CNT_EN` defined: the stall_cnt register and its increment logic are compiled in.
- Not defined: stall_cnt is tied to 16'h0000 and no counter flops exist. All other behaviour is identical.

## Test plan
- LOAD_LAT=1; E_mem_read=1, E_WB=1, E_dst_add=3, D_src_add_1=3, use_1=1 for one cycle -> one cycle with pc_en=0, fd_en=0, de_bubble=1; next cycle all enables 1; stall_cnt=1.
- LOAD_LAT=3, same hazard pulse -> pc_en=0 for exactly 3 cycles, then RUN; same registers with use_1=0 and use_2=0 -> no stall.
- M_mem_busy high 4 cycles with flush pulsed in busy cycle 2 -> all enables 0 for 4 cycles; next cycle fd_flush=1, de_bubble=1; following cycle normal.
- LOAD_LAT=3: flush on the 2nd stall cycle -> that cycle squashes (pc_en=1, fd_flush=1); next cycle RUN with no remaining stall.
- rst asserted during LOAD_STALL -> outputs go to reset values asynchronously; after release, state is RUN and stall_cnt=0.
- Build with and without HAZARD_PERF_CNT_EN; run 70000 freeze cycles -> stall_cnt=16'hFFFF with the macro, 0 without it.
